// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the single-port SRAM controller.
// The INIT state is only reachable when SRAM_CTRL_INIT_EN is defined.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_CAPT,
        ST_RESP
    } state_e;

    localparam int ADR_DEF  = 8;
    localparam int DAT_DEF  = 8;
    localparam int DPTH_DEF = 8;

    // Edges from read acceptance until the consumer first samples rsp_valid.
    localparam int RD_LAT = 3;

    function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/sram_init_seq.sv
// Address walker for the post-reset clear of the SRAM; used only when
// SRAM_CTRL_INIT_EN is defined.
module sram_init_seq
    import sram_ctrl_pkg::*;
#(
    parameter int ADR  = ADR_DEF,
    parameter int DPTH = DPTH_DEF
) (
    input  logic           Clk,
    input  logic           Rst_n,
    input  logic           en,
    output logic [ADR-1:0] addr,
    output logic           done
);

    localparam logic [ADR-1:0] LAST = ADR'(DPTH - 1);

    // Parks on the last address so done stays asserted until the next reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            addr <= '0;
        end else if (en && !done) begin
            addr <= addr + 1'b1;
        end
    end

    assign done = (addr == LAST);

endmodule

// File: rtl/sram_ctrl.sv
// Initiator-side controller for a single-port synchronous SRAM (CS/WE/RD).
// Optional post-reset zero fill of the array is enabled by SRAM_CTRL_INIT_EN.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADR  = ADR_DEF,
    parameter int DAT  = DAT_DEF,
    parameter int DPTH = DPTH_DEF
) (
    input  logic           Clk,
    input  logic           Rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_we,
    input  logic [ADR-1:0] req_addr,
    input  logic [DAT-1:0] req_wdata,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [DAT-1:0] rsp_rdata,
    output logic           rsp_err,
    output logic           CS,
    output logic           WE,
    output logic           RD,
    output logic [ADR-1:0] Addr,
    output logic [DAT-1:0] dataIn,
    input  logic [DAT-1:0] dataOut
);

    state_e         state_q;
    state_e         state_d;
    logic           cs_d;
    logic           we_d;
    logic           rd_d;
    logic [ADR-1:0] addr_d;
    logic [DAT-1:0] din_d;
    logic           rsp_valid_d;
    logic [DAT-1:0] rsp_rdata_d;
    logic           rsp_err_d;
    logic           accept;
    logic           in_range;

`ifdef SRAM_CTRL_INIT_EN
    localparam state_e RST_STATE = ST_INIT;
    logic           init_en;
    logic [ADR-1:0] init_addr;
    logic           init_done;

    assign init_en = (state_q == ST_INIT);

    sram_init_seq #(
        .ADR  (ADR),
        .DPTH (DPTH)
    ) u_init_seq (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .en    (init_en),
        .addr  (init_addr),
        .done  (init_done)
    );
`else
    localparam state_e RST_STATE = ST_IDLE;
`endif

    // Gated by Rst_n so req_ready reads 0 for the whole time reset is held.
    assign req_ready = Rst_n && (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign in_range  = addr_in_range(32'(req_addr), 32'(DPTH));

    always_comb begin
        state_d     = state_q;
        cs_d        = 1'b0;
        we_d        = 1'b0;
        rd_d        = 1'b0;
        addr_d      = Addr;
        din_d       = dataIn;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        case (state_q)
`ifdef SRAM_CTRL_INIT_EN
            ST_INIT: begin
                cs_d   = 1'b1;
                we_d   = 1'b1;
                addr_d = init_addr;
                din_d  = '0;
                if (init_done) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            ST_IDLE: begin
                if (accept) begin
                    if (req_we) begin
                        // Out-of-range writes are silently dropped.
                        if (in_range) begin
                            cs_d   = 1'b1;
                            we_d   = 1'b1;
                            addr_d = req_addr;
                            din_d  = req_wdata;
                        end
                    end else if (in_range) begin
                        cs_d    = 1'b1;
                        rd_d    = 1'b1;
                        addr_d  = req_addr;
                        state_d = ST_RD_ISSUE;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_RD_ISSUE: begin
                state_d = ST_RD_CAPT;
            end
            ST_RD_CAPT: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = dataOut;
                rsp_err_d   = 1'b0;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // SRAM pins and response channel are all registered.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            CS        <= 1'b0;
            WE        <= 1'b0;
            RD        <= 1'b0;
            Addr      <= '0;
            dataIn    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            CS        <= cs_d;
            WE        <= we_d;
            RD        <= rd_d;
            Addr      <= addr_d;
            dataIn    <= din_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

    a_we_rd_excl: assert property (@(posedge Clk) disable iff (!Rst_n) !(WE && RD));
    a_cs_gate:    assert property (@(posedge Clk) disable iff (!Rst_n) !CS |-> (!WE && !RD));
    a_rsp_hold:   assert property (@(posedge Clk) disable iff (!Rst_n)
                                   (rsp_valid && !rsp_ready) |=>
                                   (rsp_valid && $stable(rsp_rdata) && $stable(rsp_err)));

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl with a behavioural SRAM model.
module tb_sram_ctrl;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       CS;
    logic       WE;
    logic       RD;
    logic [7:0] Addr;
    logic [7:0] dataIn;
    logic [7:0] dataOut = 8'h00;

    sram_ctrl #(.ADR(8), .DAT(8), .DPTH(8)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .CS        (CS),
        .WE        (WE),
        .RD        (RD),
        .Addr      (Addr),
        .dataIn    (dataIn),
        .dataOut   (dataOut)
    );

    always #5 Clk = ~Clk;

    // Behavioural single-port SRAM: unwritten words read back as 0xEE.
    logic [7:0] mem [256] = '{default: 8'hEE};
    always @(posedge Clk) begin
        if (CS && WE) mem[Addr] <= dataIn;
        if (CS && RD) dataOut <= mem[Addr];
    end

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
        int         lat;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    int   cs_cnt = 0, we_cnt = 0, rd_cnt = 0, hs_cnt = 0;
    int   we_run = 0, last_run = 0, last_wr_cyc = 0;
    logic prev_vld = 1'b0, prev_rdy = 1'b0, prev_err = 1'b0;
    logic [7:0] prev_data = 8'h00;

    int   s_cs, s_we, s_rd, s_hs, k;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: SRAM pin rules plus response scoreboard, sampled on the falling edge.
    always @(negedge Clk) begin
        if (CS) cs_cnt <= cs_cnt + 1;
        if (CS && RD) rd_cnt <= rd_cnt + 1;
        if (CS && WE) begin
            we_cnt      <= we_cnt + 1;
            we_run      <= we_run + 1;
            last_wr_cyc <= cyc;
        end else begin
            we_run <= 0;
            if (we_run > 0) last_run <= we_run;
        end
        if (WE || RD) begin
            check("pin_cs_gate", CS, 1);
            check("pin_we_rd_excl", WE && RD, 0);
        end
        if (Rst_n) begin
            if (rsp_valid && !prev_vld) begin
                if (sb.size() == 0) check("unexpected_rsp", rsp_valid, 0);
                else check("rsp_latency", cyc - sb[0].acc, sb[0].lat);
            end
            if (rsp_valid && prev_vld && !prev_rdy) begin
                check("rsp_hold_rdata", rsp_rdata, prev_data);
                check("rsp_hold_err", rsp_err, prev_err);
            end
            if (rsp_valid && rsp_ready) begin
                hs_cnt <= hs_cnt + 1;
                if (sb.size() != 0) begin
                    check("rsp_rdata", rsp_rdata, sb[0].rdata);
                    check("rsp_err", rsp_err, sb[0].err);
                    sb.delete(0);
                end
            end
        end
        prev_vld  <= rsp_valid;
        prev_rdy  <= rsp_ready;
        prev_data <= rsp_rdata;
        prev_err  <= rsp_err;
    end

    task automatic push(input logic [7:0] rdata, input logic err, input int lat);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.lat   = lat;
        e.acc   = cyc;
        sb.push_back(e);
    endtask

    task automatic do_req(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic expect_rsp, input logic [7:0] rdata, input logic err,
                          input int lat);
        int w;
        @(posedge Clk); #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        w = 0;
        @(negedge Clk);
        while (!req_ready && w < 50) begin
            @(negedge Clk);
            w++;
        end
        if (!req_ready) begin
            check("req_accept_timeout", req_ready, 1);
        end else begin
            acc_cyc = cyc;
            if (!we && expect_rsp) push(rdata, err, lat);
        end
        @(posedge Clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 30) begin
            @(negedge Clk);
            w++;
        end
        check("rsp_drain", sb.size(), 0);
        @(posedge Clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check({tag, "_rsp_err"}, rsp_err, 0);
        check({tag, "_cs"}, CS, 0);
        check({tag, "_we"}, WE, 0);
        check({tag, "_rd"}, RD, 0);
        check({tag, "_addr"}, Addr, 0);
        check({tag, "_datain"}, dataIn, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        rsp_ready = 1'b1;

        repeat (3) @(negedge Clk);
        check_reset_outputs("rst");
        Rst_n = 1'b1;
        #1;
`ifdef SRAM_CTRL_INIT_EN
        k = 0;
        while (!req_ready && k < 40) begin
            @(negedge Clk);
            k++;
        end
        check("init_ready_cycle", k + 1, 9);
        @(posedge Clk); #1;
        for (int i = 0; i < 8; i++) check("init_zero", mem[i], 8'h00);
        do_req(1'b0, 8'd5, 8'h00, 1'b1, 8'h00, 1'b0, 3);
        wait_drain();
`else
        check("first_cycle_ready", req_ready, 1);
`endif

        // Write 0x5A to addr 3, then read it back.
        s_cs = cs_cnt; s_we = we_cnt;
        do_req(1'b1, 8'd3, 8'h5A, 1'b0, 8'h00, 1'b0, 0);
        repeat (2) @(negedge Clk);
        check("wr_cs_cycles", cs_cnt - s_cs, 1);
        check("wr_we_cycles", we_cnt - s_we, 1);
        check("wr_pin_cycle", last_wr_cyc - acc_cyc, 1);
        check("wr_mem_commit", mem[3], 8'h5A);
        s_cs = cs_cnt; s_rd = rd_cnt;
        do_req(1'b0, 8'd3, 8'h00, 1'b1, 8'h5A, 1'b0, 3);
        wait_drain();
        check("rd_cs_cycles", cs_cnt - s_cs, 1);
        check("rd_rd_cycles", rd_cnt - s_rd, 1);

        // Eight back-to-back writes with valid held, then an immediate read of addr 7.
        s_we = we_cnt;
        @(posedge Clk); #1;
        req_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            req_we    = (i < 8);
            req_addr  = (i < 8) ? 8'(i) : 8'd7;
            req_wdata = 8'hA0 + 8'(i);
            @(negedge Clk);
            check("burst_ready", req_ready, 1);
            if (i == 8) push(8'hA7, 1'b0, 3);
            @(posedge Clk); #1;
        end
        req_valid = 1'b0;
        wait_drain();
        check("burst_we_cycles", we_cnt - s_we, 8);
        check("burst_we_run", last_run, 8);
        check("burst_mem0", mem[0], 8'hA0);
        check("burst_mem5", mem[5], 8'hA5);

        // Response backpressure on a read of addr 2.
        do_req(1'b1, 8'd2, 8'h11, 1'b0, 8'h00, 1'b0, 0);
        rsp_ready = 1'b0;
        s_hs = hs_cnt;
        do_req(1'b0, 8'd2, 8'h00, 1'b1, 8'h11, 1'b0, 3);
        k = 0;
        while (!rsp_valid && k < 10) begin
            @(negedge Clk);
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_rdata", rsp_rdata, 8'h11);
            check("bp_req_ready", req_ready, 0);
            @(negedge Clk);
        end
        @(posedge Clk); #1;
        rsp_ready = 1'b1;
        wait_drain();
        check("bp_one_response", hs_cnt - s_hs, 1);

        // Out-of-range write and read (DPTH = 8).
        s_cs = cs_cnt; s_hs = hs_cnt;
        do_req(1'b1, 8'd9, 8'h77, 1'b0, 8'h00, 1'b0, 0);
        repeat (3) @(negedge Clk);
        check("oor_wr_no_cs", cs_cnt - s_cs, 0);
        check("oor_wr_no_rsp", hs_cnt - s_hs, 0);
        do_req(1'b0, 8'd9, 8'h00, 1'b1, 8'h00, 1'b1, 1);
        wait_drain();
        check("oor_rd_no_cs", cs_cnt - s_cs, 0);
        check("oor_rd_one_rsp", hs_cnt - s_hs, 1);

        // Reset asserted while the read sits in RD_CAPT.
        s_hs = hs_cnt;
        do_req(1'b0, 8'd3, 8'h00, 1'b0, 8'h00, 1'b0, 0);
        @(posedge Clk); #1;
        Rst_n = 1'b0;
        #1;
        check_reset_outputs("midrd");
        repeat (2) @(negedge Clk);
        check("midrd_hold_valid", rsp_valid, 0);
        Rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            check("midrd_no_rsp", rsp_valid, 0);
        end
        check("midrd_no_handshake", hs_cnt - s_hs, 0);
        do_req(1'b1, 8'd4, 8'h3C, 1'b0, 8'h00, 1'b0, 0);
        do_req(1'b0, 8'd4, 8'h00, 1'b1, 8'h3C, 1'b0, 3);
        wait_drain();

        repeat (3) @(posedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
